// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx
//   Camera emulator. Takes RGB565 pixels through a valid/ready handshake
//   and sends them out as OV-style DVP frames (vsync, href, 8-bit data).
//   Each pixel becomes two bytes, high byte first, on consecutive clocks
//   while href is high. Frame timing is fixed by the parameters.
//
// Ports
//   pclk_i          pixel clock, all logic on the rising edge
//   rst_i           asynchronous reset, active low
//   test_pattern_i  (only with CAM_DVP_TX_TESTPATTERN_EN) 1 = emit an
//                   index pattern instead of source pixels; sampled at
//                   frame start
//   enable_i        1 = generate frames; only looked at on frame boundaries
//   pixel_i         RGB565 pixel from the source
//   pixel_valid_i   pixel_i is valid
//   pixel_ready_o   pixel_i is taken this cycle if pixel_valid_i
//   d_o             DVP data byte
//   vsync_o         vertical sync, active high
//   href_o          line valid, active high
//   frame_start_o   one-cycle pulse in the first vsync_o-high cycle
//   underflow_o     sticky; a pixel was needed while pixel_valid_i was 0
//
// Optional feature macro: CAM_DVP_TX_TESTPATTERN_EN
//   When defined, adds test_pattern_i. A frame started with it high
//   ignores the source and emits {line_idx[7:0], pix_idx[7:0]} per pixel.

module cam_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        pclk_i,
    input  logic        rst_i,
`ifdef CAM_DVP_TX_TESTPATTERN_EN
    input  logic        test_pattern_i,
`endif
    input  logic        enable_i,
    input  logic [15:0] pixel_i,
    input  logic        pixel_valid_i,
    output logic        pixel_ready_o,
    output logic [7:0]  d_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic        frame_start_o,
    output logic        underflow_o
);

    localparam int LINE_CLKS  = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_CLKS   = 2 * H_ACTIVE;
    localparam int VSYNC_CLKS = VSYNC_LINES * LINE_CLKS;
    localparam int VBP_CLKS   = VBP_LINES * LINE_CLKS;
    localparam int VFP_CLKS   = VFP_LINES * LINE_CLKS;

    // One counter is reused by every state, so it must span the longest one.
    localparam int MAX_A   = (ACT_CLKS > H_BLANK) ? ACT_CLKS : H_BLANK;
    localparam int MAX_B   = (VSYNC_CLKS > VBP_CLKS) ? VSYNC_CLKS : VBP_CLKS;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > VFP_CLKS) ? MAX_C : VFP_CLKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LINE_W  = $clog2(V_ACTIVE + 1);

    localparam logic [CNT_W-1:0]  ACT_LAST   = CNT_W'(ACT_CLKS - 1);
    localparam logic [CNT_W-1:0]  HBL_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  VSYNC_LAST = CNT_W'(VSYNC_CLKS - 1);
    localparam logic [CNT_W-1:0]  VBP_LAST   = CNT_W'(VBP_CLKS - 1);
    localparam logic [CNT_W-1:0]  VFP_LAST   = CNT_W'(VFP_CLKS - 1);
    localparam logic [LINE_W-1:0] LINES      = LINE_W'(V_ACTIVE);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         d_q, d_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic               fs_q, fs_d;
    logic               uf_q, uf_d;
    logic               ready;
    logic [15:0]        px;
    logic               load_px;
    logic               start_frame;
    logic               end_frame;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
    logic               tp_q, tp_d;
`endif

    // Ready marks the edge that loads the next phase-0 byte: the last cycle
    // before a line starts, and every phase-1 cycle except the line's last.
    // In ACTIVE, cnt_q[0] is the byte phase currently on d_o.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            VSYNC:   ready = (VBP_CLKS == 0) && (cnt_q == VSYNC_LAST);
            VBP:     ready = (cnt_q == VBP_LAST);
            ACTIVE:  ready = cnt_q[0] && (cnt_q != ACT_LAST);
            HBLANK:  ready = (cnt_q == HBL_LAST) && (line_q < LINES);
            default: ready = 1'b0;
        endcase
`ifdef CAM_DVP_TX_TESTPATTERN_EN
        if (tp_q) begin
            ready = 1'b0;
        end
`endif
    end

    // Pixel to load on the next phase-0 edge. A missing source pixel is
    // replaced by black so the line timing never stalls. In pattern mode
    // the pixel index is the one about to start: 0 when loading from a
    // blanking state, otherwise the pixel after the current one.
    always_comb begin
        px = pixel_valid_i ? pixel_i : 16'h0000;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
        if (tp_q) begin
            px[15:8] = 8'(line_q);
            px[7:0]  = (state_q == ACTIVE) ? (8'(cnt_q >> 1) + 8'd1) : 8'h00;
        end
`endif
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so the registered outputs line up with state_q.
    // Frame start, line start and frame end are shared entry points that
    // several states can reach, hence the flags applied after the case.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        line_d      = line_q;
        lo_d        = lo_q;
        d_d         = 8'h00;
        vsync_d     = 1'b0;
        href_d      = 1'b0;
        fs_d        = 1'b0;
        uf_d        = uf_q;
        load_px     = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
        tp_d        = tp_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable_i) begin
                    start_frame = 1'b1;
                end
            end
            VSYNC: begin
                vsync_d = 1'b1;
                if (cnt_q == VSYNC_LAST) begin
                    vsync_d = 1'b0;
                    cnt_d   = '0;
                    if (VBP_CLKS == 0) begin
                        load_px = 1'b1;
                    end else begin
                        state_d = VBP;
                    end
                end
            end
            VBP: begin
                if (cnt_q == VBP_LAST) begin
                    load_px = 1'b1;
                end
            end
            ACTIVE: begin
                href_d = 1'b1;
                if (!cnt_q[0]) begin
                    d_d = lo_q;
                end else if (cnt_q == ACT_LAST) begin
                    href_d  = 1'b0;
                    state_d = HBLANK;
                    cnt_d   = '0;
                    line_d  = line_q + LINE_W'(1);
                end else begin
                    d_d  = px[15:8];
                    lo_d = px[7:0];
                end
            end
            HBLANK: begin
                if (cnt_q == HBL_LAST) begin
                    cnt_d = '0;
                    if (line_q < LINES) begin
                        load_px = 1'b1;
                    end else if (VFP_CLKS == 0) begin
                        end_frame = 1'b1;
                    end else begin
                        state_d = VFP;
                    end
                end
            end
            VFP: begin
                if (cnt_q == VFP_LAST) begin
                    end_frame = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (end_frame) begin
            cnt_d = '0;
            if (enable_i) begin
                start_frame = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
        if (start_frame) begin
            state_d = VSYNC;
            cnt_d   = '0;
            vsync_d = 1'b1;
            fs_d    = 1'b1;
            uf_d    = 1'b0;
            line_d  = '0;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
            tp_d    = test_pattern_i;
`endif
        end
        if (load_px) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            href_d  = 1'b1;
            d_d     = px[15:8];
            lo_d    = px[7:0];
        end
        if (ready && !pixel_valid_i) begin
            uf_d = 1'b1;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            lo_q    <= 8'h00;
            d_q     <= 8'h00;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
            tp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            lo_q    <= lo_d;
            d_q     <= d_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
            tp_q    <= tp_d;
`endif
        end
    end

    assign pixel_ready_o = ready;
    assign d_o           = d_q;
    assign vsync_o       = vsync_q;
    assign href_o        = href_q;
    assign frame_start_o = fs_q;
    assign underflow_o   = uf_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb_cam_dvp_tx
//   Self-checking bench for cam_dvp_tx with a small frame
//   (4 pixels x 2 lines, 3 blank clocks, one line each of vsync, back and
//   front porch: 11-clock lines, 55-clock frames). All sampling and input
//   driving happens on the falling clock edge; n / r below count falling
//   edges from the first frame_start_o cycle of a frame.

module tb_cam_dvp_tx;

    localparam int H_ACTIVE    = 4;
    localparam int H_BLANK     = 3;
    localparam int V_ACTIVE    = 2;
    localparam int VSYNC_LINES = 1;
    localparam int VBP_LINES   = 1;
    localparam int VFP_LINES   = 1;
    localparam int NV          = 23;

    logic        pclk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] pixel_i;
    logic        pixel_valid_i;
    logic        pixel_ready_o;
    logic [7:0]  d_o;
    logic        vsync_o;
    logic        href_o;
    logic        frame_start_o;
    logic        underflow_o;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
    logic        test_pattern_i;
`endif

    typedef struct {
        int         n;
        logic       valid;
        logic       vsync;
        logic       href;
        logic       fs;
        logic       rdy;
        logic       uf;
        logic [7:0] d;
    } vec_t;

    vec_t       vec [NV];
    int         checks = 0;
    int         failures = 0;
    int         src_idx;
    bit         xfer_pending;
    bit         overlap;
    int         href_cnt;
    logic [7:0] cap [$];

    cam_dvp_tx #(
        .H_ACTIVE   (H_ACTIVE),
        .H_BLANK    (H_BLANK),
        .V_ACTIVE   (V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES),
        .VBP_LINES  (VBP_LINES),
        .VFP_LINES  (VFP_LINES)
    ) dut (
        .pclk_i        (pclk_i),
        .rst_i         (rst_i),
`ifdef CAM_DVP_TX_TESTPATTERN_EN
        .test_pattern_i(test_pattern_i),
`endif
        .enable_i      (enable_i),
        .pixel_i       (pixel_i),
        .pixel_valid_i (pixel_valid_i),
        .pixel_ready_o (pixel_ready_o),
        .d_o           (d_o),
        .vsync_o       (vsync_o),
        .href_o        (href_o),
        .frame_start_o (frame_start_o),
        .underflow_o   (underflow_o)
    );

    // Free-running pixel clock, period 10.
    always #5 pclk_i = ~pclk_i;

    // Hard time limit so a stuck run still ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Source pixel stream: 0x1234, 0xABCD, then {k, k^0x5A}.
    function automatic logic [15:0] src_pix(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (k == 0) return 16'h1234;
        if (k == 1) return 16'hABCD;
        return {kb, kb ^ 8'h5A};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive valid for the coming rising edge, then advance to the next
    // falling edge. The source index moves on only after a real transfer,
    // and href bytes are captured like a DVP receiver would.
    task automatic applyStimulus(input logic valid);
        pixel_valid_i = valid;
        xfer_pending  = pixel_ready_o && valid;
        @(posedge pclk_i);
        @(negedge pclk_i);
        if (xfer_pending) src_idx++;
        pixel_i = src_pix(src_idx);
        if (href_o) begin
            cap.push_back(d_o);
            href_cnt++;
        end
        if (vsync_o && href_o) overlap = 1'b1;
    endtask

    // Rebuild the expected byte stream of one frame (8 pixels) from the
    // source; uf_pos marks a pixel replaced by black.
    task automatic checkFrame(input string name, input int base, input int uf_pos);
        logic [7:0]  exp_b [$];
        logic [15:0] p;
        int          idx;
        int          bad;
        idx = base;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == uf_pos) begin
                p = 16'h0000;
            end else begin
                p = src_pix(idx);
                idx++;
            end
            exp_b.push_back(p[15:8]);
            exp_b.push_back(p[7:0]);
        end
        checkOutput({name, "_len"}, 16'(cap.size()), 16'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < cap.size(); i++) begin
            if (cap[i] !== exp_b[i]) bad++;
        end
        checkOutput({name, "_bytes_bad"}, 16'(bad), 16'd0);
        cap.delete();
    endtask

    initial begin
        int k;
        int first_href;
        logic vld;
        bit rdy_seen;

        //            n  vld vs hr fs rdy uf d
        vec[0]  = '{ 0, 1, 1, 0, 1, 0, 0, 8'h00};
        vec[1]  = '{ 1, 1, 1, 0, 0, 0, 0, 8'h00};
        vec[2]  = '{ 5, 0, 1, 0, 0, 0, 0, 8'h00};
        vec[3]  = '{ 6, 1, 1, 0, 0, 0, 0, 8'h00};
        vec[4]  = '{10, 1, 1, 0, 0, 0, 0, 8'h00};
        vec[5]  = '{11, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[6]  = '{21, 1, 0, 0, 0, 1, 0, 8'h00};
        vec[7]  = '{22, 1, 0, 1, 0, 0, 0, 8'h12};
        vec[8]  = '{23, 1, 0, 1, 0, 1, 0, 8'h34};
        vec[9]  = '{24, 1, 0, 1, 0, 0, 0, 8'hAB};
        vec[10] = '{25, 1, 0, 1, 0, 1, 0, 8'hCD};
        vec[11] = '{26, 1, 0, 1, 0, 0, 0, 8'h02};
        vec[12] = '{29, 1, 0, 1, 0, 0, 0, 8'h59};
        vec[13] = '{30, 0, 0, 0, 0, 0, 0, 8'h00};
        vec[14] = '{31, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[15] = '{32, 1, 0, 0, 0, 1, 0, 8'h00};
        vec[16] = '{33, 1, 0, 1, 0, 0, 0, 8'h04};
        vec[17] = '{40, 1, 0, 1, 0, 0, 0, 8'h5D};
        vec[18] = '{41, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[19] = '{43, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[20] = '{44, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[21] = '{54, 1, 0, 0, 0, 0, 0, 8'h00};
        vec[22] = '{55, 1, 1, 0, 1, 0, 0, 8'h00};

        rst_i         = 1'b0;
        enable_i      = 1'b0;
        pixel_valid_i = 1'b1;
        src_idx       = 0;
        pixel_i       = src_pix(0);
        xfer_pending  = 1'b0;
        overlap       = 1'b0;
        href_cnt      = 0;
`ifdef CAM_DVP_TX_TESTPATTERN_EN
        test_pattern_i = 1'b0;
`endif

        // Reset values.
        repeat (3) @(negedge pclk_i);
        checkOutput("rst_d", 16'(d_o), 16'h0);
        checkOutput("rst_vsync", 16'(vsync_o), 16'h0);
        checkOutput("rst_href", 16'(href_o), 16'h0);
        checkOutput("rst_ready", 16'(pixel_ready_o), 16'h0);
        checkOutput("rst_fs", 16'(frame_start_o), 16'h0);
        checkOutput("rst_uf", 16'(underflow_o), 16'h0);

        // Idle with enable low stays quiet.
        rst_i = 1'b1;
        repeat (3) applyStimulus(1'b1);
        checkOutput("idle_vsync", 16'(vsync_o), 16'h0);
        checkOutput("idle_ready", 16'(pixel_ready_o), 16'h0);

        // Frame 1: table-driven timing and byte order.
        enable_i = 1'b1;
        cap.delete();
        href_cnt = 0;
        applyStimulus(1'b1);
        k = 0;
        for (int n = 0; n <= 55; n++) begin
            vld = 1'b1;
            if (k < NV && vec[k].n == n) begin
                checkOutput($sformatf("n%0d_vsync", n), 16'(vsync_o), 16'(vec[k].vsync));
                checkOutput($sformatf("n%0d_href", n), 16'(href_o), 16'(vec[k].href));
                checkOutput($sformatf("n%0d_fs", n), 16'(frame_start_o), 16'(vec[k].fs));
                checkOutput($sformatf("n%0d_ready", n), 16'(pixel_ready_o), 16'(vec[k].rdy));
                checkOutput($sformatf("n%0d_uf", n), 16'(underflow_o), 16'(vec[k].uf));
                checkOutput($sformatf("n%0d_d", n), 16'(d_o), 16'(vec[k].d));
                vld = vec[k].valid;
                k++;
            end
            if (n < 55) applyStimulus(vld);
        end
        checkOutput("vectors_hit", 16'(k), 16'(NV));
        checkFrame("frame1", 0, -1);

        // Frame 2: one missing pixel at line 0 pixel 1 (ready at r=23).
        href_cnt   = 0;
        first_href = -1;
        for (int r = 0; r < 55; r++) begin
            if (r == 24) begin
                checkOutput("uf_set", 16'(underflow_o), 16'h1);
                checkOutput("uf_hi_byte", 16'(d_o), 16'h00);
            end
            if (r == 25) checkOutput("uf_lo_byte", 16'(d_o), 16'h00);
            if (r == 54) checkOutput("uf_sticky", 16'(underflow_o), 16'h1);
            applyStimulus((r == 23) ? 1'b0 : 1'b1);
            if (href_o && first_href < 0) first_href = r + 1;
        end
        checkOutput("f2_first_href", 16'(first_href), 16'd22);
        checkOutput("f2_href_cnt", 16'(href_cnt), 16'd16);
        checkOutput("f3_fs", 16'(frame_start_o), 16'h1);
        checkOutput("uf_cleared", 16'(underflow_o), 16'h0);
        checkFrame("frame2", 8, 1);

        // Frame 3: enable dropped during line 1; frame completes, then IDLE.
        href_cnt = 0;
        for (int r = 0; r < 55; r++) begin
            if (r == 35) enable_i = 1'b0;
            applyStimulus(1'b1);
        end
        checkOutput("en_off_vsync", 16'(vsync_o), 16'h0);
        checkOutput("en_off_fs", 16'(frame_start_o), 16'h0);
        checkOutput("en_off_href", 16'(href_o), 16'h0);
        checkOutput("en_off_d", 16'(d_o), 16'h00);
        checkOutput("en_off_ready", 16'(pixel_ready_o), 16'h0);
        checkOutput("f3_href_cnt", 16'(href_cnt), 16'd16);
        checkFrame("frame3", 15, -1);
        repeat (5) applyStimulus(1'b1);
        checkOutput("en_off_hold_vsync", 16'(vsync_o), 16'h0);
        enable_i = 1'b1;
        applyStimulus(1'b1);
        checkOutput("en_on_vsync", 16'(vsync_o), 16'h1);
        checkOutput("en_on_fs", 16'(frame_start_o), 16'h1);

        // Frame 4: asynchronous reset in the middle of line 0.
        for (int r = 0; r < 25; r++) applyStimulus(1'b1);
        checkOutput("pre_rst_href", 16'(href_o), 16'h1);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("arst_d", 16'(d_o), 16'h0);
        checkOutput("arst_vsync", 16'(vsync_o), 16'h0);
        checkOutput("arst_href", 16'(href_o), 16'h0);
        checkOutput("arst_ready", 16'(pixel_ready_o), 16'h0);
        checkOutput("arst_fs", 16'(frame_start_o), 16'h0);
        checkOutput("arst_uf", 16'(underflow_o), 16'h0);
        @(negedge pclk_i);
        @(negedge pclk_i);
        rst_i = 1'b1;
        cap.delete();
        applyStimulus(1'b1);
        checkOutput("post_rst_vsync", 16'(vsync_o), 16'h1);
        checkOutput("post_rst_fs", 16'(frame_start_o), 16'h1);
        checkOutput("post_rst_href", 16'(href_o), 16'h0);
        for (int r = 0; r < 22; r++) applyStimulus(1'b1);
        checkOutput("post_rst_line_hi", 16'(d_o), 16'h19);
        applyStimulus(1'b1);
        checkOutput("post_rst_line_lo", 16'(d_o), 16'h43);

`ifdef CAM_DVP_TX_TESTPATTERN_EN
        // Pattern frame: line 1, pixel 2 emits 01,02; no source requests.
        @(negedge pclk_i);
        rst_i          = 1'b0;
        test_pattern_i = 1'b1;
        @(negedge pclk_i);
        rst_i    = 1'b1;
        rdy_seen = 1'b0;
        applyStimulus(1'b1);
        checkOutput("tp_fs", 16'(frame_start_o), 16'h1);
        for (int r = 0; r < 55; r++) begin
            if (pixel_ready_o) rdy_seen = 1'b1;
            if (r == 37) checkOutput("tp_l1p2_hi", 16'(d_o), 16'h01);
            if (r == 38) checkOutput("tp_l1p2_lo", 16'(d_o), 16'h02);
            applyStimulus(1'b1);
        end
        checkOutput("tp_ready_seen", 16'(rdy_seen), 16'h0);
        checkOutput("tp_uf", 16'(underflow_o), 16'h0);
`else
        rdy_seen = 1'b0;
`endif

        checkOutput("vsync_href_overlap", 16'(overlap), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
